// File: rtl/clip_sequencer_if.sv
// Enqueue handshake bundle for clip_sequencer.
// Master offers a clip index; slave signals room in the queue.
interface clip_sequencer_if #(
  parameter int IDX_W = 5
) ();
  logic             enq_valid;
  logic [IDX_W-1:0] enq_idx;
  logic             enq_ready;

  modport master (
    output enq_valid,
    output enq_idx,
    input  enq_ready
  );

  modport slave (
    input  enq_valid,
    input  enq_idx,
    output enq_ready
  );
endinterface

// File: rtl/clip_sequencer.sv
// Clip sequencer: queues clip indices and streams each clip's
// samples from flash to the codec on every audio strobe.
module clip_sequencer #(
  parameter int TRACK_LENGTH = 69000,
  parameter int ADDR_W       = 23,
  parameter int IDX_W        = 5,
  parameter int SEQ_DEPTH    = 4,
  parameter int SAMPLE_W     = 8,
  parameter int SKIP_IDX     = 28,
  parameter int NULL_IDX     = 31
) (
  input  logic                         clock,
  input  logic                         reset,
  clip_sequencer_if.slave              enq,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         ready,
  input  logic [15:0]                  frdata,
  output logic [ADDR_W-1:0]            raddr,
  output logic                         doread,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic                         sample_valid,
  output logic                         playing,
  output logic                         done,
  output logic [$clog2(SEQ_DEPTH):0]   queue_count
);
  localparam int PW = $clog2(SEQ_DEPTH);
  localparam logic [ADDR_W-1:0] TL    = ADDR_W'(TRACK_LENGTH);
  localparam logic [IDX_W-1:0]  SKIP  = IDX_W'(SKIP_IDX);
  localparam logic [IDX_W-1:0]  NUL   = IDX_W'(NULL_IDX);
  localparam logic [PW:0]       DEPTH = (PW+1)'(SEQ_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    mem_q [SEQ_DEPTH];
  logic [PW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d, end_q, end_d;
  logic [SAMPLE_W-1:0] smp_q, smp_d;
  logic                sv_q, sv_d, start_q;
  logic                push, pop, rise, empty, skip, fin;
  logic [IDX_W-1:0]    head;
  logic [ADDR_W-1:0]   base;
  logic                unused_fr;

  assign unused_fr     = ^frdata;
  assign empty         = (cnt_q == '0);
  assign head          = mem_q[rp_q];
  assign skip          = (head == SKIP);
  assign rise          = start & ~start_q;
  assign fin           = (raddr_q >= end_q);
  assign base          = ADDR_W'(head) * TL;
  assign enq.enq_ready = (cnt_q < DEPTH);
  assign push = enq.enq_valid & enq.enq_ready
              & (enq.enq_idx != NUL) & ~abort;
  assign pop  = (state_q == LOAD) & ~empty & ~abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      raddr_q <= '0;
      end_q   <= '0;
      smp_q   <= '0;
      sv_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      end_q   <= end_d;
      smp_q   <= smp_d;
      sv_q    <= sv_d;
      start_q <= start;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wp_q] <= enq.enq_idx;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (rise && !empty) state_d = LOAD;
        LOAD: begin
          if (empty)      state_d = DONE;
          else if (!skip) state_d = PLAY;
        end
        PLAY: if (ready && fin) state_d = LOAD;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    end_d   = end_q;
    smp_d   = smp_q;
    sv_d    = 1'b0;
    if (push) wp_d = wp_q + PW'(1);
    if (pop)  rp_d = rp_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    if (pop && !skip) begin
      raddr_d = base;
      end_d   = base + TL;
    end
    if (state_q == PLAY && ready && !fin) begin
      smp_d   = frdata[15 -: SAMPLE_W];
      raddr_d = raddr_q + ADDR_W'(1);
      sv_d    = 1'b1;
    end
    if (state_q == DONE) raddr_d = '0;
    if (state_q == IDLE) smp_d = '0;
    // abort flushes everything and suppresses any strobe this cycle
    if (abort) begin
      wp_d    = '0;
      rp_d    = '0;
      cnt_d   = '0;
      raddr_d = '0;
      smp_d   = '0;
      sv_d    = 1'b0;
    end
  end

  always_comb begin
    playing    = (state_q == LOAD) || (state_q == PLAY);
    doread     = playing;
    done       = (state_q == DONE);
    sample_out = (state_q == IDLE) ? '0 : smp_q;
  end

  assign raddr        = raddr_q;
  assign sample_valid = sv_q;
  assign queue_count  = cnt_q;
endmodule

// File: tb/tb_clip_sequencer.sv
// Scoreboard bench for clip_sequencer with a short clip length.
// Flash data at address a is {a[7:0]^8'h5A, 8'hC3}.
module tb_clip_sequencer;
  localparam int TL = 120;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] frdata;
  logic [22:0] raddr;
  logic        doread, sample_valid, playing, done;
  logic [7:0]  sample_out;
  logic [2:0]  queue_count;

  int n_tests = 0;
  int n_fail  = 0;
  int sv_cnt  = 0;
  int done_cnt = 0;
  int ph = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  clip_sequencer_if #(.IDX_W(5)) enq_if ();

  clip_sequencer #(.TRACK_LENGTH(TL)) dut (
    .clock        (clock),
    .reset        (reset),
    .enq          (enq_if),
    .start        (start),
    .abort        (abort),
    .ready        (ready),
    .frdata       (frdata),
    .raddr        (raddr),
    .doread       (doread),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .playing      (playing),
    .done         (done),
    .queue_count  (queue_count)
  );

  always #5 clock = ~clock;

  assign frdata = {raddr[7:0] ^ 8'h5A, 8'hC3};

  // one-cycle audio strobe every third cycle
  always @(negedge clock) begin
    ph = (ph == 2) ? 0 : ph + 1;
    ready = (ph == 0);
  end

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (sample_valid) begin
      sv_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sample_extra: got %0h, no sample expected",
                 sample_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (sample_out !== mon_e) begin
          n_fail++;
          $display("FAIL sample #%0d: got %0h, want %0h",
                   sv_cnt, sample_out, mon_e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic enq(input logic [4:0] idx);
    enq_if.enq_valid = 1'b1;
    enq_if.enq_idx   = idx;
    tick();
    enq_if.enq_valid = 1'b0;
  endtask

  task automatic push_clip(input int idx, input int n);
    for (int a = idx * TL; a < idx * TL + n; a++)
      exp_q.push_back(8'(a) ^ 8'h5A);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_samples(input string nm, input int target);
    int i;
    for (i = 0; i < 3000 && sv_cnt < target; i++) tick();
    if (sv_cnt < target) chk({nm, "_timeout"}, sv_cnt, target);
  endtask

  task automatic wait_done(input string nm);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(seen), 1);
    chk({nm, "_drained"}, exp_q.size(), 0);
    tick();
    chk({nm, "_idle_play"}, 32'(playing), 0);
    chk({nm, "_idle_raddr"}, raddr, 0);
    chk({nm, "_idle_sout"}, sample_out, 0);
    tick(4);
    chk({nm, "_one_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int b;
    int d0;
    bit pl;
    enq_if.enq_valid = 1'b0;
    enq_if.enq_idx   = '0;
    tick(3);
    reset = 1'b0;
    tick();
    chk("rst_enq_ready", 32'(enq_if.enq_ready), 1);
    chk("rst_count", queue_count, 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_doread", 32'(doread), 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_sout", sample_out, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_svalid", 32'(sample_valid), 0);

    enq(5'd31);
    tick();
    chk("null_count", queue_count, 0);
    d0 = done_cnt;
    pl = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      tick();
      pl |= playing;
    end
    chk("empty_start_play", 32'(pl), 0);
    chk("empty_start_done", done_cnt - d0, 0);

    enq(5'd3);
    push_clip(3, TL);
    b = sv_cnt;
    pulse_start();
    wait_samples("single", b + 1);
    chk("single_first_addr", raddr, 3 * TL + 1);
    wait_done("single");

    enq(5'd28);
    enq(5'd2);
    push_clip(2, TL);
    b = sv_cnt;
    pulse_start();
    wait_samples("skip", b + 1);
    chk("skip_first_addr", raddr, 2 * TL + 1);
    wait_done("skip");

    enq(5'd0);
    enq(5'd1);
    enq(5'd2);
    enq(5'd3);
    chk("full_enq_ready", 32'(enq_if.enq_ready), 0);
    chk("full_count", queue_count, 4);
    enq(5'd5);
    chk("full_drop_count", queue_count, 4);
    for (int c = 0; c < 4; c++) push_clip(c, TL);
    pulse_start();
    wait_done("full");

    enq(5'd6);
    enq(5'd9);
    push_clip(6, TL);
    push_clip(9, TL);
    push_clip(11, TL);
    pulse_start();
    enq(5'd11);
    chk("pop_push_count", queue_count, 2);
    wait_done("refill");

    enq(5'd7);
    push_clip(7, TL);
    b = sv_cnt;
    pulse_start();
    wait_samples("append", b + 1);
    chk("append_first_addr", raddr, 7 * TL + 1);
    enq(5'd4);
    push_clip(4, TL);
    wait_done("append");

    enq(5'd1);
    enq(5'd5);
    enq(5'd6);
    push_clip(1, 100);
    b = sv_cnt;
    d0 = done_cnt;
    pulse_start();
    wait_samples("abort", b + 100);
    chk("abort_pre_count", queue_count, 2);
    abort = 1'b1;
    enq_if.enq_valid = 1'b1;
    enq_if.enq_idx   = 5'd9;
    tick();
    abort = 1'b0;
    enq_if.enq_valid = 1'b0;
    chk("abort_playing", 32'(playing), 0);
    chk("abort_count", queue_count, 0);
    chk("abort_raddr", raddr, 0);
    chk("abort_sout", sample_out, 0);
    chk("abort_svalid", 32'(sample_valid), 0);
    tick(8);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_enq_dropped", queue_count, 0);
    chk("abort_drained", exp_q.size(), 0);

    enq(5'd2);
    enq(5'd3);
    push_clip(2, 20);
    b = sv_cnt;
    d0 = done_cnt;
    pulse_start();
    wait_samples("rstplay", b + 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstplay_playing", 32'(playing), 0);
    chk("rstplay_raddr", raddr, 0);
    chk("rstplay_count", queue_count, 0);
    chk("rstplay_enq_ready", 32'(enq_if.enq_ready), 1);
    chk("rstplay_sout", sample_out, 0);
    tick(8);
    chk("rstplay_no_done", done_cnt - d0, 0);
    chk("rstplay_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
